beat_sequencer: RTL and testbench

//  Steps through the beats of the selected song, one beat per rising edge of play_clk from
//  the speed controller. Sits between the speed controller and the note ROM/tone generator.

---
 rtl/music_pkg.sv | 16 +
 rtl/tick_detect.sv | 49 ++++
 rtl/beat_sequencer.sv | 113 +++++++++++
 tb/tb_beat_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the beat sequencer: state encoding, song length table, default beat width.
package music_pkg;

    localparam int DEFAULT_BEAT_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Beats per song; every entry must be at least 1 and fit in DEFAULT_BEAT_W bits.
    localparam int SONG_LEN [4] = '{4, 8, 6, 1};

endpackage

// File: rtl/tick_detect.sv
// Synchronises the beat-rate clock as data and emits a one-cycle tick per accepted rising edge,
// rejecting edges that arrive less than MIN_GAP cycles after the previous raw edge.
module tick_detect #(
    parameter int MIN_GAP = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic play_clk_i,
    output logic tick_o
);

    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;
    logic             raw_edge;

    assign raw_edge = sync2_q & ~prev_q;
    assign tick_o   = raw_edge && (gap_q >= GAP_MAX);

    // Every raw edge restarts the gap, so a burst of mux glitches keeps being rejected.
    always_comb begin
        gap_d = gap_q;
        if (raw_edge) begin
            gap_d = '0;
        end else if (gap_q < GAP_MAX) begin
            gap_d = gap_q + GAP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            gap_q   <= GAP_MAX;
        end else begin
            sync1_q <= play_clk_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// Steps through the beats of the selected song on each accepted play_clk tick, with
// play/pause/stop control, song select, end-of-song stop or loop, and a per-beat strobe.
module beat_sequencer
    import music_pkg::*;
#(
    parameter int BEAT_W  = DEFAULT_BEAT_W,
    parameter int MIN_GAP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play_clk,
    input  logic              play_pause,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [1:0]        song_sel,
    output logic [BEAT_W-1:0] beat_idx,
    output logic [1:0]        song,
    output logic              beat_stb,
    output logic              playing,
    output logic [1:0]        state,
    output logic              song_done
);

    state_t            state_q;
    logic [BEAT_W-1:0] beat_idx_q;
    logic [1:0]        song_q;
    logic              beat_stb_q;
    logic              playing_q;
    logic              song_done_q;
    logic              tick;
    logic [BEAT_W-1:0] last_beat;

    tick_detect #(
        .MIN_GAP (MIN_GAP)
    ) u_tick_detect (
        .clk        (clk),
        .rst        (rst),
        .play_clk_i (play_clk),
        .tick_o     (tick)
    );

    // Length comes from the registered song so the index and its bound always refer to the same song.
    assign last_beat = BEAT_W'(SONG_LEN[song_q] - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_idx_q  <= '0;
            song_q      <= 2'd0;
            beat_stb_q  <= 1'b0;
            playing_q   <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            beat_stb_q  <= 1'b0;
            song_done_q <= 1'b0;
            if (stop) begin
                state_q    <= ST_IDLE;
                beat_idx_q <= '0;
                playing_q  <= 1'b0;
            end else if (song_sel != song_q) begin
                song_q     <= song_sel;
                beat_idx_q <= '0;
                case (state_q)
                    ST_PLAY: beat_stb_q <= 1'b1;
                    ST_DONE: begin
                        state_q   <= ST_PAUSE;
                        playing_q <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (play_pause) begin
                case (state_q)
                    ST_PLAY: begin
                        state_q   <= ST_PAUSE;
                        playing_q <= 1'b0;
                    end
                    ST_PAUSE: begin
                        state_q   <= ST_PLAY;
                        playing_q <= 1'b1;
                    end
                    default: begin
                        state_q    <= ST_PLAY;
                        playing_q  <= 1'b1;
                        beat_idx_q <= '0;
                        beat_stb_q <= 1'b1;
                    end
                endcase
            end else if (tick && state_q == ST_PLAY) begin
                if (beat_idx_q >= last_beat) begin
                    song_done_q <= 1'b1;
                    if (loop_en) begin
                        beat_idx_q <= '0;
                        beat_stb_q <= 1'b1;
                    end else begin
                        state_q   <= ST_DONE;
                        playing_q <= 1'b0;
                    end
                end else begin
                    beat_idx_q <= beat_idx_q + BEAT_W'(1);
                    beat_stb_q <= 1'b1;
                end
            end
        end
    end

    assign beat_idx  = beat_idx_q;
    assign song      = song_q;
    assign beat_stb  = beat_stb_q;
    assign playing   = playing_q;
    assign state     = state_q;
    assign song_done = song_done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboard bench for beat_sequencer: expected strobes are queued with the stimulus and
// checked as the DUT strobes; control and timing scenarios are checked inline.
module tb_beat_sequencer;

    logic       clk;
    logic       rst;
    logic       play_clk;
    logic       play_pause;
    logic       stop;
    logic       loop_en;
    logic [1:0] song_sel;
    logic [8:0] beat_idx;
    logic [1:0] song;
    logic       beat_stb;
    logic       playing;
    logic [1:0] state;
    logic       song_done;

    typedef struct {
        logic [8:0] idx;
        logic [1:0] song;
        logic       done;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    beat_sequencer #(.BEAT_W(9), .MIN_GAP(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .play_clk   (play_clk),
        .play_pause (play_pause),
        .stop       (stop),
        .loop_en    (loop_en),
        .song_sel   (song_sel),
        .beat_idx   (beat_idx),
        .song       (song),
        .beat_stb   (beat_stb),
        .playing    (playing),
        .state      (state),
        .song_done  (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every strobe must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && beat_stb) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL strobe_unexpected: got idx=%0d song=%0d done=%0d, required no strobe", beat_idx, song, song_done);
            end else begin
                e = q.pop_front();
                if ({beat_idx, song, song_done} !== {e.idx, e.song, e.done}) begin
                    fails++;
                    $display("FAIL strobe: got idx=%0d song=%0d done=%0d, required idx=%0d song=%0d done=%0d",
                             beat_idx, song, song_done, e.idx, e.song, e.done);
                end else begin
                    $display("[TB] beat idx=%0d song=%0d done=%0d", beat_idx, song, song_done);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int idx, input int sng, input bit done);
        exp_t x;
        x.idx  = 9'(idx);
        x.song = 2'(sng);
        x.done = done;
        q.push_back(x);
    endtask

    task automatic pulse_pp();
        play_pause = 1'b1;
        cyc(1);
        play_pause = 1'b0;
    endtask

    task automatic tick_fall();
        cyc(29);
        play_clk = 1'b0;
        cyc(32);
    endtask

    task automatic full_tick();
        play_clk = 1'b1;
        cyc(3);
        tick_fall();
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({state, beat_idx, song, beat_stb, playing, song_done} !== 16'd0) begin
            fails++;
            $display("FAIL reset_outputs: got state=%0d idx=%0d song=%0d stb=%0d playing=%0d done=%0d, required all 0",
                     state, beat_idx, song, beat_stb, playing, song_done);
        end
        cyc(2);
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_play_once();
        loop_en  = 1'b0;
        song_sel = 2'd0;
        push_exp(0, 0, 0);
        pulse_pp();
        tests++;
        if (state !== 2'd1 || playing !== 1'b1) begin
            fails++;
            $display("FAIL play_start: got state=%0d playing=%0d, required state=1 playing=1", state, playing);
        end
        for (int i = 1; i <= 3; i++) begin
            push_exp(i, 0, 0);
            play_clk = 1'b1;
            cyc(2);
            tests++;
            if (beat_idx !== 9'(i - 1) || beat_stb !== 1'b0) begin
                fails++;
                $display("FAIL latency_early: got idx=%0d stb=%0d, required idx=%0d stb=0", beat_idx, beat_stb, i - 1);
            end
            cyc(1);
            tick_fall();
        end
        play_clk = 1'b1;
        cyc(3);
        tests++;
        if ({song_done, state, beat_idx, beat_stb} !== {1'b1, 2'd3, 9'd3, 1'b0}) begin
            fails++;
            $display("FAIL song_end_stop: got done=%0d state=%0d idx=%0d stb=%0d, required done=1 state=3 idx=3 stb=0",
                     song_done, state, beat_idx, beat_stb);
        end
        tick_fall();
        tests++;
        if ({song_done, state, beat_idx, playing} !== {1'b0, 2'd3, 9'd3, 1'b0}) begin
            fails++;
            $display("FAIL done_hold: got done=%0d state=%0d idx=%0d playing=%0d, required 0 3 3 0",
                     song_done, state, beat_idx, playing);
        end
    endtask

    task automatic test_loop();
        loop_en = 1'b1;
        push_exp(0, 0, 0);
        pulse_pp();
        for (int i = 1; i <= 3; i++) begin
            push_exp(i, 0, 0);
            full_tick();
        end
        push_exp(0, 0, 1);
        full_tick();
        tests++;
        if (state !== 2'd1 || beat_idx !== 9'd0) begin
            fails++;
            $display("FAIL loop_stay_play: got state=%0d idx=%0d, required state=1 idx=0", state, beat_idx);
        end
        push_exp(1, 0, 0);
        full_tick();
        push_exp(2, 0, 0);
        full_tick();
    endtask

    task automatic test_pause();
        pulse_pp();
        tests++;
        if (state !== 2'd2 || beat_idx !== 9'd2 || playing !== 1'b0) begin
            fails++;
            $display("FAIL pause_enter: got state=%0d idx=%0d playing=%0d, required 2 2 0", state, beat_idx, playing);
        end
        for (int i = 0; i < 5; i++) full_tick();
        tests++;
        if (beat_idx !== 9'd2 || state !== 2'd2) begin
            fails++;
            $display("FAIL pause_ignores_ticks: got idx=%0d state=%0d, required idx=2 state=2", beat_idx, state);
        end
        pulse_pp();
        tests++;
        if ({state, beat_idx, beat_stb} !== {2'd1, 9'd2, 1'b0}) begin
            fails++;
            $display("FAIL resume: got state=%0d idx=%0d stb=%0d, required 1 2 0", state, beat_idx, beat_stb);
        end
        push_exp(3, 0, 0);
        full_tick();
    endtask

    task automatic test_min_gap();
        push_exp(0, 0, 1);
        play_clk = 1'b1;
        cyc(4);
        play_clk = 1'b0;
        cyc(4);
        play_clk = 1'b1;
        cyc(4);
        play_clk = 1'b0;
        tests++;
        if (beat_idx !== 9'd0) begin
            fails++;
            $display("FAIL gap_first_edge: got idx=%0d, required 0", beat_idx);
        end
        cyc(4);
        tests++;
        if (beat_idx !== 9'd0) begin
            fails++;
            $display("FAIL gap_reject: got idx=%0d, required 0", beat_idx);
        end
        push_exp(1, 0, 0);
        cyc(12);
        play_clk = 1'b1;
        cyc(3);
        tests++;
        if (beat_idx !== 9'd1) begin
            fails++;
            $display("FAIL gap_accept: got idx=%0d, required 1", beat_idx);
        end
        tick_fall();
    endtask

    task automatic test_song_change();
        push_exp(2, 0, 0);
        full_tick();
        push_exp(0, 2, 0);
        play_clk = 1'b1;
        cyc(2);
        song_sel = 2'd2;
        cyc(1);
        tests++;
        if ({state, song, beat_idx} !== {2'd1, 2'd2, 9'd0}) begin
            fails++;
            $display("FAIL song_change: got state=%0d song=%0d idx=%0d, required 1 2 0", state, song, beat_idx);
        end
        tick_fall();
        tests++;
        if (beat_idx !== 9'd0) begin
            fails++;
            $display("FAIL tick_dropped: got idx=%0d, required 0", beat_idx);
        end
        push_exp(1, 2, 0);
        full_tick();
    endtask

    task automatic test_stop_and_reset();
        stop       = 1'b1;
        play_pause = 1'b1;
        cyc(1);
        stop       = 1'b0;
        play_pause = 1'b0;
        tests++;
        if ({state, beat_idx, playing} !== {2'd0, 9'd0, 1'b0}) begin
            fails++;
            $display("FAIL stop_priority: got state=%0d idx=%0d playing=%0d, required 0 0 0", state, beat_idx, playing);
        end
        push_exp(0, 2, 0);
        pulse_pp();
        push_exp(1, 2, 0);
        full_tick();
        play_clk = 1'b1;
        cyc(2);
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({state, beat_idx, song, beat_stb, playing, song_done} !== 16'd0) begin
            fails++;
            $display("FAIL async_reset: got state=%0d idx=%0d song=%0d stb=%0d playing=%0d done=%0d, required all 0",
                     state, beat_idx, song, beat_stb, playing, song_done);
        end
        cyc(1);
        rst = 1'b0;
        song_sel = 2'd0;
        tick_fall();
        tests++;
        if ({state, beat_idx, song} !== {2'd0, 9'd0, 2'd0}) begin
            fails++;
            $display("FAIL after_reset: got state=%0d idx=%0d song=%0d, required 0 0 0", state, beat_idx, song);
        end
    endtask

    initial begin
        rst        = 1'b1;
        play_clk   = 1'b0;
        play_pause = 1'b0;
        stop       = 1'b0;
        loop_en    = 1'b0;
        song_sel   = 2'd0;
        test_reset();
        test_play_once();
        test_loop();
        test_pause();
        test_min_gap();
        test_song_change();
        test_stop_and_reset();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_strobes: got %0d beats never strobed, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
